// File: rtl/i2c_target_regs.sv
// i2c_target_regs: I2C target giving a bus controller strobe access to an 8-bit register space
module i2c_target_regs #(
   parameter logic [6:0] DEV_ADDR = 7'h36,
   parameter int         SYNC_FF  = 2
) (
   input  logic       clk_i,
   input  logic       rstn_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe_o,
   output logic [7:0] reg_addr_o,
   output logic [7:0] reg_wdata_o,
   output logic       reg_we_o,
   output logic       reg_rd_o,
   input  logic [7:0] reg_rdata_i,
   output logic       busy_o
);
   typedef enum logic [3:0] {IDLE, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK, WAIT} state_t;
   state_t state_q, state_d;
   logic [SYNC_FF-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic scl_h_q, scl_h_d, sda_h_q, sda_h_d;
   logic [7:0] sr_q, sr_d, addr_q, addr_d, wdata_q, wdata_d;
   logic [3:0] cnt_q, cnt_d;
   logic oe_q, oe_d, we_q, we_d, rd_q, rd_d, rw_q, rw_d;
   logic scl, sda, scl_rise, scl_fall, start, stop, byte_done;
   logic [7:0] byte_in;
   assign scl       = scl_sync_q[SYNC_FF-1];
   assign sda       = sda_sync_q[SYNC_FF-1];
   assign scl_rise  = scl & ~scl_h_q;
   assign scl_fall  = ~scl & scl_h_q;
   assign start     = scl & scl_h_q & sda_h_q & ~sda;
   assign stop      = scl & scl_h_q & ~sda_h_q & sda;
   assign byte_in   = {sr_q[6:0], sda};
   assign byte_done = cnt_q == 4'd7;
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= IDLE;
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_h_q    <= 1'b1;
         sda_h_q    <= 1'b1;
         sr_q       <= 8'h00;
         addr_q     <= 8'h00;
         wdata_q    <= 8'h00;
         cnt_q      <= 4'd0;
         oe_q       <= 1'b0;
         we_q       <= 1'b0;
         rd_q       <= 1'b0;
         rw_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         scl_sync_q <= scl_sync_d;
         sda_sync_q <= sda_sync_d;
         scl_h_q    <= scl_h_d;
         sda_h_q    <= sda_h_d;
         sr_q       <= sr_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         oe_q       <= oe_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         rw_q       <= rw_d;
      end
   end
   always_comb begin
      state_d = state_q;
      if (start) state_d = ADDR;
      else if (stop) state_d = IDLE;
      else if (scl_rise) begin
         case (state_q)
            ADDR:    if (byte_done) state_d = (byte_in[7:1] == DEV_ADDR) ? ACK_A : IDLE;
            ACK_A:   if (rw_q) state_d = RDATA;
            PTR:     if (byte_done) state_d = ACK_P;
            WDATA:   if (byte_done) state_d = ACK_W;
            MACK:    state_d = sda ? WAIT : RDATA;
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ACK_A:         if (oe_q) state_d = PTR;
            ACK_P, ACK_W:  if (oe_q) state_d = WDATA;
            RDATA:         if (cnt_q == 4'd8) state_d = MACK;
            default: ;
         endcase
      end
   end
   // ACK states use oe_q as their phase: the first fall starts the ACK, the second ends it
   always_comb begin
      scl_sync_d = {scl_sync_q[SYNC_FF-2:0], scl_i};
      sda_sync_d = {sda_sync_q[SYNC_FF-2:0], sda_i};
      scl_h_d    = scl;
      sda_h_d    = sda;
      sr_d       = rd_q ? reg_rdata_i : sr_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      oe_d       = oe_q;
      rw_d       = rw_q;
      we_d       = 1'b0;
      rd_d       = 1'b0;
      if (start || stop) begin
         cnt_d = 4'd0;
         oe_d  = 1'b0;
      end else if (scl_rise) begin
         if (state_q == ADDR || state_q == PTR || state_q == WDATA) begin
            sr_d  = byte_in;
            cnt_d = byte_done ? 4'd0 : cnt_q + 4'd1;
         end
         if (state_q == ADDR && byte_done) rw_d = sda;
         if (state_q == PTR && byte_done) addr_d = byte_in;
         if (state_q == WDATA && byte_done) begin
            wdata_d = byte_in;
            we_d    = 1'b1;
         end
         if (state_q == ACK_A && rw_q) begin
            rd_d  = 1'b1;
            cnt_d = 4'd0;
         end
         if (state_q == MACK && !sda) begin
            addr_d = addr_q + 8'd1;
            rd_d   = 1'b1;
            cnt_d  = 4'd0;
         end
      end else if (scl_fall) begin
         if (state_q == ACK_A || state_q == ACK_P || state_q == ACK_W) oe_d = ~oe_q;
         if (state_q == ACK_W && oe_q) addr_d = addr_q + 8'd1;
         if (state_q == RDATA) begin
            oe_d  = (cnt_q == 4'd8) ? 1'b0 : ~sr_q[7];
            sr_d  = (cnt_q == 4'd8) ? sr_q : {sr_q[6:0], 1'b0};
            cnt_d = (cnt_q == 4'd8) ? cnt_q : cnt_q + 4'd1;
         end
      end
   end
   always_comb begin
      sda_oe_o    = oe_q;
      reg_addr_o  = addr_q;
      reg_wdata_o = wdata_q;
      reg_we_o    = we_q;
      reg_rd_o    = rd_q;
      busy_o      = state_q != IDLE;
   end
endmodule

// File: tb/tb_i2c_target_regs.sv
// tb_i2c_target_regs: drives an open-drain I2C controller model against i2c_target_regs
module tb_i2c_target_regs;
   logic clk_i = 1'b0, rstn_i = 1'b0, scl_m = 1'b1, sda_m = 1'b1;
   logic sda_oe_o, reg_we_o, reg_rd_o, busy_o, sda_line;
   logic [7:0] reg_addr_o, reg_wdata_o, reg_rdata_i;
   logic [7:0] mem [256];
   logic [7:0] we_a [64], we_dat [64], rd_a [64];
   int we_n = 0, rd_n = 0, oe_n = 0, both_n = 0, wide_n = 0;
   logic we_prev = 1'b0, rd_prev = 1'b0;
   int n_tot = 0, n_pass = 0;

   typedef struct {
      logic [7:0] dev, ptr, d0, d1;
      int         n;
      logic       exp_ack;
      int         exp_we;
      logic [7:0] a0, a1;
   } wvec_t;
   wvec_t wv [5];

   assign sda_line    = sda_m & ~sda_oe_o;
   assign reg_rdata_i = mem[reg_addr_o];

   i2c_target_regs dut (
      .clk_i(clk_i), .rstn_i(rstn_i), .scl_i(scl_m), .sda_i(sda_line),
      .sda_oe_o(sda_oe_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
      .reg_we_o(reg_we_o), .reg_rd_o(reg_rd_o), .reg_rdata_i(reg_rdata_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   always @(negedge clk_i) begin
      if (reg_we_o) begin
         if (we_n < 64) begin
            we_a[we_n]   <= reg_addr_o;
            we_dat[we_n] <= reg_wdata_o;
         end
         we_n <= we_n + 1;
      end
      if (reg_rd_o) begin
         if (rd_n < 64) rd_a[rd_n] <= reg_addr_o;
         rd_n <= rd_n + 1;
      end
      if (sda_oe_o) oe_n <= oe_n + 1;
      if (reg_we_o && reg_rd_o) both_n <= both_n + 1;
      if ((reg_we_o && we_prev) || (reg_rd_o && rd_prev)) wide_n <= wide_n + 1;
      we_prev <= reg_we_o;
      rd_prev <= reg_rd_o;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk_i);
   endtask

   task automatic bus_start();
      tick(5); sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(10); sda_m = 1'b0; tick(10); scl_m = 1'b0;
   endtask

   task automatic bus_stop();
      tick(5); sda_m = 1'b0; tick(5); scl_m = 1'b1; tick(10); sda_m = 1'b1; tick(10);
   endtask

   task automatic send_bit(input logic b);
      tick(5); sda_m = b; tick(5); scl_m = 1'b1; tick(10); scl_m = 1'b0;
   endtask

   task automatic recv_bit(output logic b);
      tick(5); sda_m = 1'b1; tick(5); scl_m = 1'b1; tick(5); b = sda_line; tick(5); scl_m = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v, output logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
      recv_bit(b);
      ack = ~b;
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] v);
      logic b;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b);
         v = {v[6:0], b};
      end
      send_bit(mack);
   endtask

   initial begin
      logic ack;
      logic [7:0] d;
      int wb, rb, ob;
      wv[0] = '{8'h6C, 8'h10, 8'hA5, 8'h5A, 2, 1'b1, 2, 8'h10, 8'h11};
      wv[1] = '{8'h70, 8'h10, 8'hFF, 8'h00, 1, 1'b0, 0, 8'h00, 8'h00};
      wv[2] = '{8'h6C, 8'hFF, 8'h11, 8'h22, 2, 1'b1, 2, 8'hFF, 8'h00};
      wv[3] = '{8'h6C, 8'h40, 8'hC3, 8'h00, 1, 1'b1, 1, 8'h40, 8'h00};
      wv[4] = '{8'h6E, 8'h40, 8'h99, 8'h00, 1, 1'b0, 0, 8'h00, 8'h00};
      for (int i = 0; i < 256; i++) mem[i] = 8'(i);
      mem[8'h20] = 8'h3C;
      mem[8'h21] = 8'hC3;
      tick(3);
      chk("rst sda_oe", sda_oe_o, 0);
      chk("rst we", reg_we_o, 0);
      chk("rst rd", reg_rd_o, 0);
      chk("rst busy", busy_o, 0);
      chk("rst addr", reg_addr_o, 0);
      chk("rst wdata", reg_wdata_o, 0);
      rstn_i = 1'b1;
      tick(5);

      for (int v = 0; v < 5; v++) begin
         wb = we_n; ob = oe_n;
         bus_start();
         send_byte(wv[v].dev, ack);
         chk($sformatf("v%0d dev ack", v), ack, wv[v].exp_ack);
         chk($sformatf("v%0d busy after addr", v), busy_o, wv[v].exp_ack);
         send_byte(wv[v].ptr, ack);
         chk($sformatf("v%0d ptr ack", v), ack, wv[v].exp_ack);
         send_byte(wv[v].d0, ack);
         chk($sformatf("v%0d d0 ack", v), ack, wv[v].exp_ack);
         if (wv[v].n > 1) begin
            send_byte(wv[v].d1, ack);
            chk($sformatf("v%0d d1 ack", v), ack, wv[v].exp_ack);
         end
         bus_stop();
         chk($sformatf("v%0d busy after stop", v), busy_o, 0);
         chk($sformatf("v%0d we count", v), we_n - wb, wv[v].exp_we);
         chk($sformatf("v%0d sda driven", v), oe_n != ob, wv[v].exp_ack);
         if (wv[v].exp_we > 0) begin
            chk($sformatf("v%0d we0 addr", v), we_a[wb], wv[v].a0);
            chk($sformatf("v%0d we0 data", v), we_dat[wb], wv[v].d0);
         end
         if (wv[v].exp_we > 1) begin
            chk($sformatf("v%0d we1 addr", v), we_a[wb + 1], wv[v].a1);
            chk($sformatf("v%0d we1 data", v), we_dat[wb + 1], wv[v].d1);
         end
      end

      // write pointer, repeated START, read two bytes with ACK then NACK
      rb = rd_n;
      bus_start();
      send_byte(8'h6C, ack); chk("rd dev-w ack", ack, 1);
      send_byte(8'h20, ack); chk("rd ptr ack", ack, 1);
      bus_start();
      send_byte(8'h6D, ack); chk("rd dev-r ack", ack, 1);
      recv_byte(1'b0, d); chk("rd byte0", d, 8'h3C);
      recv_byte(1'b1, d); chk("rd byte1", d, 8'hC3);
      bus_stop();
      chk("rd strobes", rd_n - rb, 2);
      chk("rd0 addr", rd_a[rb], 8'h20);
      chk("rd1 addr", rd_a[rb + 1], 8'h21);
      chk("rd busy after stop", busy_o, 0);

      // pointer set by a write-only transfer persists into the next read
      rb = rd_n;
      bus_start();
      send_byte(8'h6C, ack);
      send_byte(8'h21, ack);
      bus_stop();
      bus_start();
      send_byte(8'h6D, ack); chk("persist dev-r ack", ack, 1);
      recv_byte(1'b1, d); chk("persist data", d, 8'hC3);
      bus_stop();
      chk("persist rd addr", rd_a[rb], 8'h21);

      // STOP in the middle of a data byte discards it
      wb = we_n;
      bus_start();
      send_byte(8'h6C, ack);
      send_byte(8'h30, ack);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      bus_stop();
      chk("partial no we", we_n - wb, 0);
      chk("partial busy", busy_o, 0);
      bus_start();
      send_byte(8'h6C, ack);
      send_byte(8'h05, ack);
      send_byte(8'h77, ack); chk("after partial ack", ack, 1);
      bus_stop();
      chk("after partial we count", we_n - wb, 1);
      chk("after partial addr", we_a[wb], 8'h05);
      chk("after partial data", we_dat[wb], 8'h77);

      // reset while driving a read bit releases SDA at once; FSM then ignores SCL until START
      bus_start();
      send_byte(8'h6C, ack);
      send_byte(8'h20, ack);
      bus_start();
      send_byte(8'h6D, ack);
      tick(5);
      chk("pre-reset sda_oe", sda_oe_o, 1);
      #1 rstn_i = 1'b0;
      #1 chk("async reset sda_oe", sda_oe_o, 0);
      chk("reset busy", busy_o, 0);
      chk("reset addr", reg_addr_o, 0);
      tick(3);
      rstn_i = 1'b1;
      ob = oe_n; wb = we_n; rb = rd_n;
      send_byte(8'h6C, ack); chk("post-reset no ack", ack, 0);
      send_byte(8'h00, ack);
      chk("post-reset busy", busy_o, 0);
      chk("post-reset sda idle", oe_n - ob, 0);
      chk("post-reset no strobes", (we_n - wb) + (rd_n - rb), 0);
      bus_stop();

      chk("we and rd never together", both_n, 0);
      chk("strobes one clk wide", wide_n, 0);
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
